// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
// MSB-first bit-serial magnitude comparator for two WIDTH-bit operands,
// unsigned or two's-complement per operation, under a start/busy/done
// handshake. G/E/L are registered and only change on the done edge.
//
// Build option: SERIAL_CMP_EARLY_EXIT_EN
//   defined   - finish on the first differing bit (1..WIDTH cycles)
//   undefined - constant-time: always scan all WIDTH bits, finish on t(WIDTH)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands/flags held; start accepted here
// RUN   | scanning bit idx of captured operands, one bit per clock
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             E,
  output logic             L
);

  // Guard the clog2 so an illegal WIDTH still reaches the error below
  // instead of failing on a zero-width vector first.
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_mag_comparator: WIDTH must be 2 or more");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             g_q, g_d;
  logic             e_q, e_d;
  logic             l_q, l_d;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
  // First difference seen so far in the scan, and whether A won it.
  logic             found_q, found_d;
  logic             fg_q, fg_d;
`endif

  logic bit_a;
  logic bit_b;
  logic bits_differ;
  logic at_msb;
  logic at_lsb;
  logic a_wins;

  assign bit_a       = a_q[idx_q];
  assign bit_b       = b_q[idx_q];
  assign bits_differ = bit_a ^ bit_b;
  assign at_msb      = (idx_q == IDX_MAX);
  assign at_lsb      = (idx_q == '0);
  // On a differing bit, the operand holding the 1 is larger, except at the
  // sign bit of a signed compare where the 1 marks the negative operand.
  assign a_wins      = (sgn_q && at_msb) ? ~bit_a : bit_a;

  // Next-state, datapath capture and result flags.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    found_d = found_q;
    fg_d    = fg_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          idx_d   = IDX_MAX;
          busy_d  = 1'b1;
          state_d = ST_RUN;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
          found_d = 1'b0;
          fg_d    = 1'b0;
`endif
        end
      end

      ST_RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (bits_differ) begin
          g_d     = a_wins;
          l_d     = ~a_wins;
          e_d     = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (at_lsb) begin
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        // Only the first (most significant) difference decides; later
        // differences are scanned but ignored so timing is data-independent.
        if (!found_q && bits_differ) begin
          found_d = 1'b1;
          fg_d    = a_wins;
        end
        if (at_lsb) begin
          g_d     = found_d & fg_d;
          l_d     = found_d & ~fg_d;
          e_d     = ~found_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
    end
  end

`ifndef SERIAL_CMP_EARLY_EXIT_EN
  // First-difference tracking for the constant-time scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q <= 1'b0;
      fg_q    <= 1'b0;
    end else begin
      found_q <= found_d;
      fg_q    <= fg_d;
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign G    = g_q;
  assign E    = e_q;
  assign L    = l_q;

endmodule
